// File: rtl/osd_dem_uart_16550_rx.sv
// Receive side of the 16550 UART emulation: host character stream -> FIFO -> RBR/LSR register window.
// Define OSD_DEM_UART_RX_IRQ_EN to build IER/IIR interrupt support; otherwise irq is tied low.
module osd_dem_uart_16550_rx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_req,
    input  logic [2:0] bus_addr,
    input  logic       bus_write,
    input  logic [7:0] bus_wdata,
    output logic       bus_ack,
    output logic [7:0] bus_rdata,
    input  logic       drop,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        REG_RBR = 3'd0,
        REG_IER = 3'd1,
        REG_IIR = 3'd2,
        REG_LCR = 3'd3,
        REG_MCR = 3'd4,
        REG_LSR = 3'd5,
        REG_MSR = 3'd6,
        REG_SCR = 3'd7
    } reg_addr_e;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [7:0]    lcr, scr;
    logic          overrun;
    logic [7:0]    ier_val, iir_val;

    logic full, empty, dlab, rd_acc, wr_acc, push, pop, ovr_set, lsr_rd;
    reg_addr_e addr;

    assign addr     = reg_addr_e'(bus_addr);
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign dlab     = lcr[7];
    assign in_ready = !rst && (!full || drop);
    assign push     = in_valid && in_ready && !full;
    assign ovr_set  = in_valid && in_ready && full;
    assign rd_acc   = bus_req && !bus_write;
    assign wr_acc   = bus_req && bus_write;
    assign pop      = rd_acc && (addr == REG_RBR) && !dlab && !empty;
    assign lsr_rd   = rd_acc && (addr == REG_LSR);
    assign bus_ack  = 1'b1;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_char;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            lcr     <= '0;
            scr     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A fresh overrun wins over the clear-on-read of LSR in the same cycle
            if (ovr_set)     overrun <= 1'b1;
            else if (lsr_rd) overrun <= 1'b0;
            if (wr_acc && addr == REG_LCR) lcr <= bus_wdata;
            if (wr_acc && addr == REG_SCR) scr <= bus_wdata;
        end
    end

`ifdef OSD_DEM_UART_RX_IRQ_EN
    logic ier_rda, ier_rls;

    always_ff @(posedge clk) begin
        if (rst) begin
            ier_rda <= 1'b0;
            ier_rls <= 1'b0;
        end else if (wr_acc && addr == REG_IER && !dlab) begin
            ier_rda <= bus_wdata[0];
            ier_rls <= bus_wdata[2];
        end
    end

    assign ier_val = {5'b00000, ier_rls, 1'b0, ier_rda};
    assign irq     = (ier_rda && !empty) || (ier_rls && overrun);

    always_comb begin
        iir_val = 8'h01;
        if (ier_rls && overrun)    iir_val = 8'h06;
        else if (ier_rda && !empty) iir_val = 8'h04;
    end
`else
    assign ier_val = '0;
    assign iir_val = 8'h01;
    assign irq     = 1'b0;
`endif

    always_comb begin
        bus_rdata = '0;
        case (addr)
            REG_RBR: if (!dlab && !empty) bus_rdata = mem[rd_ptr];
            REG_IER: if (!dlab) bus_rdata = ier_val;
            REG_IIR: bus_rdata = iir_val;
            REG_LCR: bus_rdata = lcr;
            REG_LSR: bus_rdata = {1'b0, 1'b1, 1'b1, 3'b000, overrun, !empty};
            REG_SCR: bus_rdata = scr;
            default: bus_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_osd_dem_uart_16550_rx.sv
// Scoreboard bench for osd_dem_uart_16550_rx: reads queue expected data, a negedge monitor compares.
module tb_osd_dem_uart_16550_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic       bus_req;
    logic [2:0] bus_addr;
    logic       bus_write;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic       drop;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       irq;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    osd_dem_uart_16550_rx #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .drop(drop), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // Monitor: every read access presented to the DUT is matched against the scoreboard
    always @(negedge clk) begin
        if (bus_req === 1'b1 && bus_write === 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL read_unexpected: addr=%0d got=%02h expected no read", bus_addr, bus_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus_rdata !== e.val || bus_ack !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s: got rdata=%02h ack=%b expected rdata=%02h ack=1",
                             e.name, bus_rdata, bus_ack, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Read issued in the current cycle; inputs other than the bus are left as they are
    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string name);
        exp_t x;
        x.name = name;
        x.val  = e;
        exp_q.push_back(x);
        bus_req = 1'b1; bus_write = 1'b0; bus_addr = a;
        tick();
        bus_req = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus_req = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_req = 1'b0; bus_write = 1'b0;
    endtask

    task automatic push(input logic [7:0] c);
        in_valid = 1'b1; in_char = c;
        chk("push_ready", {7'b0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus_req = 1'b0; bus_addr = '0; bus_write = 1'b0; bus_wdata = '0;
        drop = 1'b0; in_valid = 1'b1; in_char = 8'hEE;
        tick(); tick();
        chk("ready_in_reset", {7'b0, in_ready}, 8'h00);
        chk("irq_in_reset", {7'b0, irq}, 8'h00);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("ready_after_reset", {7'b0, in_ready}, 8'h01);

        rd(3'd5, 8'h60, "reset_lsr");
        rd(3'd3, 8'h00, "reset_lcr");
        rd(3'd7, 8'h00, "reset_scr");
        rd(3'd1, 8'h00, "reset_ier");
        rd(3'd2, 8'h01, "reset_iir");
        rd(3'd0, 8'h00, "reset_rbr_empty");

        // Three back-to-back characters
        in_valid = 1'b1;
        in_char = 8'h41; tick();
        in_char = 8'h42; tick();
        in_char = 8'h43; tick();
        in_valid = 1'b0;
        rd(3'd5, 8'h61, "lsr_dr");
        rd(3'd0, 8'h41, "rbr_41");
        rd(3'd0, 8'h42, "rbr_42");
        rd(3'd0, 8'h43, "rbr_43");
        rd(3'd5, 8'h60, "lsr_drained");
        rd(3'd0, 8'h00, "rbr_drained");

        // Fill to full with drop=0, then hold a 17th character across one pop
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        in_valid = 1'b1; in_char = 8'h90;
        #1;
        chk("ready_full", {7'b0, in_ready}, 8'h00);
        tick();
        chk("ready_full_held", {7'b0, in_ready}, 8'h00);
        rd(3'd0, 8'h80, "rbr_full_pop");
        chk("ready_after_pop", {7'b0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        #1;
        chk("ready_refull", {7'b0, in_ready}, 8'h00);

        // Full with drop=1: accepted on the wire, discarded, overrun flagged
        drop = 1'b1;
        #1;
        chk("ready_drop_full", {7'b0, in_ready}, 8'h01);
        push(8'h55);
        rd(3'd5, 8'h63, "lsr_overrun");
        rd(3'd5, 8'h61, "lsr_overrun_cleared");
        for (int i = 0; i < 15; i++) rd(3'd0, 8'h81 + 8'(i), "rbr_wrap_order");
        rd(3'd0, 8'h90, "rbr_wrap_last");
        rd(3'd5, 8'h60, "lsr_after_wrap");
        drop = 1'b0;

        // Push and RBR read in the same cycle while empty: no bypass
        in_valid = 1'b1; in_char = 8'h10;
        rd(3'd0, 8'h00, "rbr_no_bypass");
        in_valid = 1'b0;
        rd(3'd0, 8'h10, "rbr_after_bypass");

        // DLAB gating of addresses 0/1
        push(8'h22);
        wr(3'd3, 8'h80);
        rd(3'd0, 8'h00, "dll_read");
        rd(3'd1, 8'h00, "dlm_read");
        wr(3'd0, 8'h99);
        rd(3'd5, 8'h61, "lsr_dlab_no_pop");
        rd(3'd3, 8'h80, "lcr_80");
        wr(3'd3, 8'h03);
        rd(3'd3, 8'h03, "lcr_03");
        rd(3'd0, 8'h22, "rbr_after_dlab");
        rd(3'd5, 8'h60, "lsr_after_dlab");

        wr(3'd7, 8'hA5);
        rd(3'd7, 8'hA5, "scr_rw");
        wr(3'd4, 8'hFF);
        rd(3'd4, 8'h00, "mcr_read");
        rd(3'd6, 8'h00, "msr_read");

`ifdef OSD_DEM_UART_RX_IRQ_EN
        wr(3'd1, 8'hFF);
        rd(3'd1, 8'h05, "ier_mask");
        wr(3'd1, 8'h05);
        push(8'h33);
        chk("irq_rda", {7'b0, irq}, 8'h01);
        rd(3'd2, 8'h04, "iir_rda");
        for (int i = 0; i < 15; i++) push(8'hC0 + 8'(i));
        drop = 1'b1;
        push(8'h55);
        drop = 1'b0;
        rd(3'd2, 8'h06, "iir_rls");
        rd(3'd5, 8'h63, "lsr_irq_overrun");
        rd(3'd0, 8'h33, "rbr_irq_first");
        for (int i = 0; i < 15; i++) rd(3'd0, 8'hC0 + 8'(i), "rbr_irq_drain");
        chk("irq_clear", {7'b0, irq}, 8'h00);
        rd(3'd2, 8'h01, "iir_none");
        wr(3'd1, 8'h00);
`else
        wr(3'd1, 8'h05);
        rd(3'd1, 8'h00, "ier_absent");
        push(8'h33);
        chk("irq_tied_low", {7'b0, irq}, 8'h00);
        rd(3'd2, 8'h01, "iir_absent");
        rd(3'd0, 8'h33, "rbr_irq_absent");
`endif

        // Reset mid-stream discards FIFO and registers
        push(8'h44);
        rst = 1'b1; in_valid = 1'b1; in_char = 8'h77;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        rd(3'd5, 8'h60, "lsr_after_rst");
        rd(3'd0, 8'h00, "rbr_after_rst");
        rd(3'd3, 8'h00, "lcr_after_rst");

        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
